// File: rtl/wb_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : wb_bus_arbiter
// Purpose  : Two-master Wishbone arbiter. The CPU instruction port (wb_I_*)
//            and data port (wb_D_*) share one Wishbone slave bus (wb_S_*).
//            Round-robin grant, bus lock while the owner holds cyc, and an
//            ack watchdog that aborts a hung cycle with an error pulse.
// Ports    : clk_i, rst_i        - clock, synchronous active-high reset
//            wb_I_* / wb_D_*     - master ports (adr/dat/sel/we/cyc/stb in,
//                                  dat/ack/err out)
//            wb_S_*              - slave port (adr/dat/sel/we/cyc/stb out,
//                                  dat/ack in)
//            grant_o             - owner status: 00 none, 01 I, 10 D
// Revision : 1.0 - initial release
// ============================================================================
module wb_bus_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int SEL_WIDTH  = 4,
  parameter int TIMEOUT    = 255,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  // instruction master
  input  logic [ADDR_WIDTH-1:0] wb_I_adr_i,
  input  logic [DATA_WIDTH-1:0] wb_I_dat_i,
  input  logic [SEL_WIDTH-1:0]  wb_I_sel_i,
  input  logic                  wb_I_we_i,
  input  logic                  wb_I_cyc_i,
  input  logic                  wb_I_stb_i,
  output logic [DATA_WIDTH-1:0] wb_I_dat_o,
  output logic                  wb_I_ack_o,
  output logic                  wb_I_err_o,
  // data master
  input  logic [ADDR_WIDTH-1:0] wb_D_adr_i,
  input  logic [DATA_WIDTH-1:0] wb_D_dat_i,
  input  logic [SEL_WIDTH-1:0]  wb_D_sel_i,
  input  logic                  wb_D_we_i,
  input  logic                  wb_D_cyc_i,
  input  logic                  wb_D_stb_i,
  output logic [DATA_WIDTH-1:0] wb_D_dat_o,
  output logic                  wb_D_ack_o,
  output logic                  wb_D_err_o,
  // shared slave
  output logic [ADDR_WIDTH-1:0] wb_S_adr_o,
  output logic [DATA_WIDTH-1:0] wb_S_dat_o,
  output logic [SEL_WIDTH-1:0]  wb_S_sel_o,
  output logic                  wb_S_we_o,
  output logic                  wb_S_cyc_o,
  output logic                  wb_S_stb_o,
  input  logic [DATA_WIDTH-1:0] wb_S_dat_i,
  input  logic                  wb_S_ack_i,
  // status
  output logic [1:0]            grant_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    GNT_I = 2'b01,
    GNT_D = 2'b10
  } state_t;

  localparam logic                 c_WD_EN    = (TIMEOUT != 0);
  localparam logic [CNT_WIDTH-1:0] c_WD_LIMIT = CNT_WIDTH'(TIMEOUT);

  state_t               r_state;
  logic                 r_last_d;   // 0: I served last, 1: D served last
  logic [CNT_WIDTH-1:0] r_wd_cnt;

  logic w_own_i;
  logic w_own_d;
  logic w_cyc;
  logic w_stb;
  logic w_timeout;
  logic w_active;

  // Ownership is masked by rst_i so every output is quiet while reset is held,
  // even though the state register only clears on the next edge.
  assign w_own_i = (r_state == GNT_I) && !rst_i;
  assign w_own_d = (r_state == GNT_D) && !rst_i;

  assign w_cyc = (w_own_i && wb_I_cyc_i) || (w_own_d && wb_D_cyc_i);
  assign w_stb = (w_own_i && wb_I_stb_i) || (w_own_d && wb_D_stb_i);

  // An ack in the limit cycle wins over the watchdog.
  assign w_timeout = c_WD_EN && w_cyc && w_stb && !wb_S_ack_i &&
                     (r_wd_cnt == c_WD_LIMIT);
  assign w_active  = w_cyc && !w_timeout;

  // Zero-latency request mux from the owning master to the slave.
  always_comb begin
    wb_S_adr_o = '0;
    wb_S_dat_o = '0;
    wb_S_sel_o = '0;
    wb_S_we_o  = 1'b0;
    if (w_active && w_own_i) begin
      wb_S_adr_o = wb_I_adr_i;
      wb_S_dat_o = wb_I_dat_i;
      wb_S_sel_o = wb_I_sel_i;
      wb_S_we_o  = wb_I_we_i;
    end else if (w_active && w_own_d) begin
      wb_S_adr_o = wb_D_adr_i;
      wb_S_dat_o = wb_D_dat_i;
      wb_S_sel_o = wb_D_sel_i;
      wb_S_we_o  = wb_D_we_i;
    end
  end

  assign wb_S_cyc_o = w_active;
  assign wb_S_stb_o = w_active && w_stb;

  // Acks are only forwarded while the owner still holds cyc; an ack arriving
  // as the master drops cyc is a protocol violation and is swallowed.
  assign wb_I_ack_o = w_own_i && wb_I_cyc_i && wb_S_ack_i;
  assign wb_D_ack_o = w_own_d && wb_D_cyc_i && wb_S_ack_i;
  assign wb_I_err_o = w_own_i && w_timeout;
  assign wb_D_err_o = w_own_d && w_timeout;
  assign wb_I_dat_o = w_own_i ? wb_S_dat_i : '0;
  assign wb_D_dat_o = w_own_d ? wb_S_dat_i : '0;

  assign grant_o = {w_own_d, w_own_i};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state  <= IDLE;
      r_last_d <= 1'b0;
      r_wd_cnt <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_wd_cnt <= '0;
          if (wb_I_cyc_i && wb_D_cyc_i) begin
            r_state <= r_last_d ? GNT_I : GNT_D;
          end else if (wb_D_cyc_i) begin
            r_state <= GNT_D;
          end else if (wb_I_cyc_i) begin
            r_state <= GNT_I;
          end
        end
        GNT_I, GNT_D: begin
          if (!w_cyc || w_timeout) begin
            // Release always passes through one IDLE cycle.
            r_state  <= IDLE;
            r_last_d <= (r_state == GNT_D);
            r_wd_cnt <= '0;
          end else if (c_WD_EN && w_stb && !wb_S_ack_i) begin
            r_wd_cnt <= r_wd_cnt + CNT_WIDTH'(1);
          end else begin
            r_wd_cnt <= '0;
          end
        end
        default: begin
          r_state  <= IDLE;
          r_wd_cnt <= '0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_wb_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_bus_arbiter
// Purpose  : Self-checking bench for wb_bus_arbiter (TIMEOUT = 5).
//            Directed vector table, directed corner sequences, then
//            randomized traffic against a transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_bus_arbiter;

  localparam int TO = 5;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [31:0] I_adr, I_dat, D_adr, D_dat, S_din;
  logic [3:0]  I_sel, D_sel;
  logic        I_we, I_cyc, I_stb, D_we, D_cyc, D_stb, S_ack;
  logic [31:0] I_dout, D_dout, S_adr, S_dout;
  logic [3:0]  S_sel;
  logic        I_ack, I_err, D_ack, D_err, S_we, S_cyc, S_stb;
  logic [1:0]  grant;

  int n_tests = 0;
  int n_fail  = 0;

  wb_bus_arbiter #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .SEL_WIDTH(4), .TIMEOUT(TO), .CNT_WIDTH(8)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .wb_I_adr_i(I_adr), .wb_I_dat_i(I_dat), .wb_I_sel_i(I_sel), .wb_I_we_i(I_we),
    .wb_I_cyc_i(I_cyc), .wb_I_stb_i(I_stb), .wb_I_dat_o(I_dout),
    .wb_I_ack_o(I_ack), .wb_I_err_o(I_err),
    .wb_D_adr_i(D_adr), .wb_D_dat_i(D_dat), .wb_D_sel_i(D_sel), .wb_D_we_i(D_we),
    .wb_D_cyc_i(D_cyc), .wb_D_stb_i(D_stb), .wb_D_dat_o(D_dout),
    .wb_D_ack_o(D_ack), .wb_D_err_o(D_err),
    .wb_S_adr_o(S_adr), .wb_S_dat_o(S_dout), .wb_S_sel_o(S_sel), .wb_S_we_o(S_we),
    .wb_S_cyc_o(S_cyc), .wb_S_stb_o(S_stb), .wb_S_dat_i(S_din), .wb_S_ack_i(S_ack),
    .grant_o(grant)
  );

  // in  = {rst, I_cyc, I_stb, D_cyc, D_stb, S_ack}
  // exp = {grant[1:0], S_cyc, S_stb, I_ack, D_ack, I_err, D_err}
  typedef struct {
    logic [5:0] in;
    logic [7:0] exp;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Control outputs, plus the data path whenever a transfer is expected.
  task automatic check_ctl(input string name, input logic [7:0] exp);
    chk(name, 128'({grant, S_cyc, S_stb, I_ack, D_ack, I_err, D_err}), 128'(exp));
    if (exp[5])
      chk({name, "/adr"}, 128'(S_adr), 128'((exp[7:6] == 2'b01) ? I_adr : D_adr));
    if (exp[3]) chk({name, "/idat"}, 128'(I_dout), 128'(S_din));
    if (exp[2]) chk({name, "/ddat"}, 128'(D_dout), 128'(S_din));
  endtask

  // Drive one cycle after the edge, check mid-cycle, advance to the next cycle.
  task automatic step(input logic [5:0] in, input logic [7:0] exp, input string name);
    {rst, I_cyc, I_stb, D_cyc, D_stb, S_ack} = in;
    #3;
    check_ctl(name, exp);
    @(posedge clk);
    #1;
  endtask

  // Reference model state: owner 0 none / 1 I / 2 D, last served master,
  // and the run length of strobed cycles still waiting for an ack.
  int m_own, m_last, m_wait;

  task automatic random_phase(input int n);
    logic [1:0]  eg;
    logic        esc, ess, eia, eda, eie, ede, mc, ms;
    int          nxt_own, nxt_last, nxt_wait;
    for (int k = 0; k < n; k++) begin
      rst   = ($urandom_range(63) == 0);
      if ($urandom_range(3) == 0) I_cyc = ~I_cyc;
      if ($urandom_range(3) == 0) D_cyc = ~D_cyc;
      I_stb = ($urandom_range(3) != 0);
      D_stb = ($urandom_range(3) != 0);
      S_ack = ($urandom_range(4) == 0);
      I_adr = $urandom; I_dat = $urandom; I_sel = 4'($urandom); I_we = 1'($urandom);
      D_adr = $urandom; D_dat = $urandom; D_sel = 4'($urandom); D_we = 1'($urandom);
      S_din = $urandom;
      #3;
      eg = 2'b00; esc = 0; ess = 0; eia = 0; eda = 0; eie = 0; ede = 0;
      nxt_own = m_own; nxt_last = m_last; nxt_wait = m_wait;
      if (rst) begin
        nxt_own = 0; nxt_last = 0; nxt_wait = 0;
      end else if (m_own == 0) begin
        nxt_wait = 0;
        if (I_cyc && D_cyc) nxt_own = (m_last == 0) ? 2 : 1;
        else if (D_cyc)     nxt_own = 2;
        else if (I_cyc)     nxt_own = 1;
      end else begin
        mc = (m_own == 1) ? I_cyc : D_cyc;
        ms = (m_own == 1) ? I_stb : D_stb;
        eg = (m_own == 1) ? 2'b01 : 2'b10;
        if (!mc) begin
          nxt_own = 0; nxt_last = m_own - 1; nxt_wait = 0;
        end else if (m_wait >= TO && ms && !S_ack) begin
          if (m_own == 1) eie = 1; else ede = 1;
          nxt_own = 0; nxt_last = m_own - 1; nxt_wait = 0;
        end else begin
          esc = 1; ess = ms;
          if (m_own == 1) eia = S_ack; else eda = S_ack;
          nxt_wait = (ms && !S_ack) ? m_wait + 1 : 0;
        end
      end
      chk("rand/ctl", 128'({grant, S_cyc, S_stb, I_ack, D_ack, I_err, D_err}),
          128'({eg, esc, ess, eia, eda, eie, ede}));
      if (esc)
        chk("rand/req", 128'({S_adr, S_dout, S_sel, S_we}),
            128'((m_own == 1) ? {I_adr, I_dat, I_sel, I_we} : {D_adr, D_dat, D_sel, D_we}));
      if (eia) chk("rand/idat", 128'(I_dout), 128'(S_din));
      if (eda) chk("rand/ddat", 128'(D_dout), 128'(S_din));
      @(posedge clk);
      #1;
      m_own = nxt_own; m_last = nxt_last; m_wait = nxt_wait;
    end
  endtask

  initial begin
    rst = 1; I_cyc = 0; I_stb = 0; D_cyc = 0; D_stb = 0; S_ack = 0;
    I_adr = 32'h100; I_dat = 32'hAAAA0001; I_sel = 4'hF; I_we = 0;
    D_adr = 32'h200; D_dat = 32'hBBBB0002; D_sel = 4'h3; D_we = 1;
    S_din = 32'hCAFE1234;
    @(posedge clk);
    #1;

    // Basic I transfer, then simultaneous requests and alternation.
    tbl.push_back('{6'b100000, 8'b00_000000});
    tbl.push_back('{6'b011000, 8'b00_000000});
    tbl.push_back('{6'b011000, 8'b01_110000});
    tbl.push_back('{6'b011000, 8'b01_110000});
    tbl.push_back('{6'b011001, 8'b01_111000});
    tbl.push_back('{6'b000000, 8'b01_000000});
    tbl.push_back('{6'b000000, 8'b00_000000});
    tbl.push_back('{6'b100000, 8'b00_000000});
    tbl.push_back('{6'b011110, 8'b00_000000});
    tbl.push_back('{6'b011110, 8'b10_110000});
    tbl.push_back('{6'b011111, 8'b10_110100});
    tbl.push_back('{6'b011000, 8'b10_000000});
    tbl.push_back('{6'b011110, 8'b00_000000});
    tbl.push_back('{6'b011110, 8'b01_110000});
    tbl.push_back('{6'b011111, 8'b01_111000});
    tbl.push_back('{6'b000110, 8'b01_000000});
    tbl.push_back('{6'b011110, 8'b00_000000});
    tbl.push_back('{6'b011110, 8'b10_110000});
    tbl.push_back('{6'b000000, 8'b10_000000});
    tbl.push_back('{6'b000000, 8'b00_000000});
    for (int i = 0; i < tbl.size(); i++)
      step(tbl[i].in, tbl[i].exp, $sformatf("vec%0d", i));

    // D burst with a stb gap while I requests: lock held until D drops cyc.
    step(6'b000110, 8'b00_000000, "burst0");
    step(6'b011111, 8'b10_110100, "burst1");
    step(6'b011111, 8'b10_110100, "burst2");
    step(6'b011100, 8'b10_100000, "burst_gap");
    step(6'b011111, 8'b10_110100, "burst3");
    step(6'b011111, 8'b10_110100, "burst4");
    step(6'b011000, 8'b10_000000, "burst_rel");
    step(6'b011000, 8'b00_000000, "burst_idle");
    step(6'b011000, 8'b01_110000, "burst_igrant");
    step(6'b000000, 8'b01_000000, "burst_irel");
    step(6'b000000, 8'b00_000000, "burst_end");

    // Watchdog: err on the 6th strobed cycle without ack.
    step(6'b011000, 8'b00_000000, "wd_req");
    for (int i = 1; i <= 5; i++)
      step(6'b011000, 8'b01_110000, $sformatf("wd_stb%0d", i));
    step(6'b011000, 8'b01_000010, "wd_err");
    step(6'b000000, 8'b00_000000, "wd_idle");

    // Ack in the limit cycle wins; grant retained.
    step(6'b011000, 8'b00_000000, "wa_req");
    for (int i = 1; i <= 5; i++)
      step(6'b011000, 8'b01_110000, $sformatf("wa_stb%0d", i));
    step(6'b011001, 8'b01_111000, "wa_ack");
    step(6'b011000, 8'b01_110000, "wa_keep");
    step(6'b000000, 8'b01_000000, "wa_rel");
    step(6'b000000, 8'b00_000000, "wa_idle");

    // Reset during a D grant: outputs quiet, last_served back to I.
    step(6'b000110, 8'b00_000000, "rm_req");
    step(6'b000110, 8'b10_110000, "rm_gnt");
    step(6'b100111, 8'b00_000000, "rm_rst");
    step(6'b011110, 8'b00_000000, "rm_idle");
    step(6'b011110, 8'b10_110000, "rm_dfirst");
    step(6'b000000, 8'b10_000000, "rm_rel");
    step(6'b000000, 8'b00_000000, "rm_end");

    // Randomized traffic from a fresh reset.
    step(6'b100000, 8'b00_000000, "rand_rst");
    m_own = 0; m_last = 0; m_wait = 0;
    I_cyc = 0; D_cyc = 0;
    random_phase(800);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/wb_bus_arbiter.md
Name: wb_bus_arbiter

Overview:
- Two-master Wishbone arbiter for the CPU's instruction port (wb_I_*) and data port (wb_D_*).
- Shares one Wishbone slave bus, e.g. a unified on-chip RAM/flash, between the two ports.
- Sits between the core top level and the memory/peripheral interconnect.
- Round-robin grant, bus lock while the granted master holds cyc, and an ack watchdog that aborts hung cycles with an error.

Parameters:
- ADDR_WIDTH, 32, address width of all ports.
- DATA_WIDTH, 32, data width of all ports.
- SEL_WIDTH, 4, byte-select width.
- TIMEOUT, 255, cycles of stb without ack before abort; 0 disables the watchdog.
- CNT_WIDTH, 8, watchdog counter width; must hold TIMEOUT.

Ports:
- clk_i  in  1  clock; all state changes on rising edge.
- rst_i  in  1  synchronous active-high reset.
- wb_I_adr_i  in  ADDR_WIDTH  instruction master address.
- wb_I_dat_i  in  DATA_WIDTH  instruction master write data.
- wb_I_sel_i  in  SEL_WIDTH  instruction master byte selects.
- wb_I_we_i  in  1  instruction master write enable.
- wb_I_cyc_i  in  1  instruction master cycle / bus request.
- wb_I_stb_i  in  1  instruction master strobe.
- wb_I_dat_o  out  DATA_WIDTH  read data to instruction master.
- wb_I_ack_o  out  1  ack to instruction master.
- wb_I_err_o  out  1  watchdog error to instruction master.
- wb_D_* (adr_i, dat_i, sel_i, we_i, cyc_i, stb_i, dat_o, ack_o, err_o): identical set for the data master.
- wb_S_adr_o  out  ADDR_WIDTH  slave address.
- wb_S_dat_o  out  DATA_WIDTH  slave write data.
- wb_S_sel_o  out  SEL_WIDTH  slave byte selects.
- wb_S_we_o  out  1  slave write enable.
- wb_S_cyc_o  out  1  slave cycle.
- wb_S_stb_o  out  1  slave strobe.
- wb_S_dat_i  in  DATA_WIDTH  slave read data.
- wb_S_ack_i  in  1  slave ack.
- grant_o  out  2  current owner: 00 none, 01 I, 10 D; debug/status.

Behaviour:
- States: IDLE, GNT_I, GNT_D. Registered state; last_served flag (0=I, 1=D); watchdog counter wd_cnt.
- Reset: state=IDLE, last_served=I (so the first simultaneous request goes to D), wd_cnt=0.
  - All outputs are 0 during and after reset until a grant: grant_o=00, wb_S_cyc_o/stb_o/we_o=0, all ack_o/err_o=0.
- IDLE arbitration:
  - Only D cyc high -> GNT_D. Only I cyc high -> GNT_I.
  - Both high -> grant the master not equal to last_served.
  - Arbitration latency is 1 cycle: request seen in cycle N, slave strobed in cycle N+1.
- GNT_x:
  - wb_S_adr/dat/sel/we/cyc/stb are driven combinationally from master x.
  - wb_x_dat_o=wb_S_dat_i; wb_x_ack_o=wb_S_ack_i.
  - The other master's ack_o/err_o are held 0; its dat_o is don't-care and is driven 0.
- Lock: grant is held while wb_x_cyc_i=1, including multi-beat bursts and idle gaps with stb=0.
- Release: on the cycle wb_x_cyc_i=0:
  - slave cyc/stb go 0 combinationally;
  - next state IDLE; last_served<=x.
  - There is always exactly one IDLE cycle between grants.
- Watchdog, when TIMEOUT!=0:
  - wd_cnt increments each cycle with wb_S_stb_o=1 and wb_S_ack_i=0.
  - wd_cnt clears on ack, on stb=0 and in IDLE.
  - When wd_cnt==TIMEOUT: wb_x_err_o=1 for that cycle, wb_S_cyc_o/stb_o forced 0, next state IDLE, last_served<=x.
  - The master must drop cyc after err. If it holds cyc, it re-arbitrates normally.
- Ack and timeout in the same cycle: ack wins; no err; counter clears.
- Ack in the same cycle the master drops cyc: the ack is ignored. It is a master protocol violation and is not forwarded.
- Reset mid-transfer: immediate return to reset values on the next edge; slave cyc drops; no ack/err emitted.
- The arbiter adds no registers in the data/ack path; it is zero-latency once granted.

Test Plan:
- Reset, then I cyc/stb=1 at cycle 0 with adr 0x100 -> grant_o=01 and wb_S_adr_o=0x100 at cycle 1; slave ack at cycle 3 -> wb_I_ack_o=1 at cycle 3; I drops cyc at cycle 4 -> grant_o=00 at cycle 5.
- Simultaneous I and D requests after reset -> D granted first. After D releases, I granted after one IDLE cycle. Repeat with both requesting continuously -> grants alternate D, I, D, I.
- D holds cyc for a 4-beat burst with a stb=0 gap while I requests -> grant_o stays 10 for all beats; I sees no ack; I granted only after D cyc=0.
- TIMEOUT=5, slave never acks I -> wb_I_err_o=1 exactly at the 6th stb cycle (wd_cnt==5); slave cyc=0 that cycle; state IDLE next.
- Ack arriving on the same cycle wd_cnt==TIMEOUT -> ack_o=1, err_o=0, grant retained.
- rst_i asserted during a D grant with stb=1 -> next cycle grant_o=00, wb_S_cyc_o=0, no ack/err pulses; last_served=I.
